// File: rtl/text_term_writer.sv
// Terminal-style byte-stream writer feeding the character RAM write port.
// Sweeps the buffer with FILL after reset or form-feed, then prints bytes at a wrapping cursor.
module text_term_writer #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 60,
  parameter int         RAM_SIZE = COLS * ROWS,
  parameter int         ADDR_W   = $clog2(RAM_SIZE),
  parameter int         COL_W    = $clog2(COLS),
  parameter int         ROW_W    = $clog2(ROWS),
  parameter logic [7:0] FILL     = 8'h20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        din,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic              busy
);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(RAM_SIZE - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  state_t            state, state_d;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_d;
  logic [COL_W-1:0]  col_d;
  logic [ROW_W-1:0]  row_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [7:0]        din_d;
  logic              accept;
  logic [ADDR_W-1:0] cell_addr;

  // Rows wrap to the top instead of scrolling.
  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
    return (r == ROW_LAST) ? '0 : r + ROW_W'(1);
  endfunction

  assign in_ready  = (state == IDLE);
  assign busy      = (state == CLEAR);
  assign accept    = in_valid && in_ready;
  assign cell_addr = ADDR_W'(cursor_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state;
    clr_cnt_d = clr_cnt;
    col_d     = cursor_col;
    row_d     = cursor_row;
    we_d      = 1'b0;
    waddr_d   = waddr;
    din_d     = din;

    case (state)
      CLEAR: begin
        we_d      = 1'b1;
        waddr_d   = clr_cnt;
        din_d     = FILL;
        clr_cnt_d = clr_cnt + ADDR_W'(1);
        if (clr_cnt == CLR_LAST) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          col_d     = '0;
          row_d     = '0;
        end
      end

      IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            we_d    = 1'b1;
            waddr_d = cell_addr;
            din_d   = in_data;
            if (cursor_col == COL_LAST) begin
              col_d = '0;
              row_d = next_row(cursor_row);
            end else begin
              col_d = cursor_col + COL_W'(1);
            end
          end else begin
            case (in_data)
              CH_CR: col_d = '0;
              CH_LF: row_d = next_row(cursor_row);
              CH_BS: if (cursor_col != '0) col_d = cursor_col - COL_W'(1);
              CH_FF: begin
                // Cursor is homed only when the sweep finishes.
                state_d   = CLEAR;
                clr_cnt_d = '0;
              end
              default: ;
            endcase
          end
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      write_en   <= 1'b0;
      waddr      <= '0;
      din        <= '0;
    end else begin
      state      <= state_d;
      clr_cnt    <= clr_cnt_d;
      cursor_col <= col_d;
      cursor_row <= row_d;
      write_en   <= we_d;
      waddr      <= waddr_d;
      din        <= din_d;
    end
  end

endmodule

// File: tb/tb_text_term_writer.sv
// Scoreboard bench for text_term_writer: tests queue expected RAM writes, a monitor pops and compares them.
module tb_text_term_writer;

  localparam int RAM_SIZE = 4800;
  localparam int BOUND    = 6000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        write_en;
  logic [12:0] waddr;
  logic [7:0]  din;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  text_term_writer dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .write_en   (write_en),
    .waddr      (waddr),
    .din        (din),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  wr_cnt   = 0;
  int  cyc      = 0;
  int  last_wr_cyc = 0;
  int  prev_wr_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push(input int addr, input logic [7:0] data);
    exp_q.push_back('{addr: 13'(addr), data: data});
  endtask

  task automatic push_clear();
    for (int i = 0; i < RAM_SIZE; i++) push(i, 8'h20);
  endtask

  // Present a byte from a falling edge and return right after the rising edge that accepts it.
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3 * BOUND) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check({name, "_col"}, 32'(cursor_col), 32'(col));
    check({name, "_row"}, 32'(cursor_row), 32'(row));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_write_en"}, 32'(write_en), 32'd0);
    check({name, "_waddr"}, 32'(waddr), 32'd0);
    check({name, "_din"}, 32'(din), 32'd0);
    check_cursor(name, 0, 0);
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (resetn && write_en) begin
      wr_cnt++;
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(waddr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(waddr), 32'(e.addr));
        check("wr_data", 32'(din), 32'(e.data));
      end
    end
  end

  initial begin
    int base;
    int n;

    // Reset state and power-on clear sweep
    #3;
    check_reset_values("reset");
    push_clear();
    #19 resetn = 1'b1;
    drain("clear0");
    check("clear0_count", 32'(wr_cnt), 32'd4800);
    check("clear0_in_ready", 32'(in_ready), 32'd1);
    check("clear0_busy", 32'(busy), 32'd0);
    check_cursor("clear0", 0, 0);

    // Back-to-back printables
    push(0, 8'h41);
    push(1, 8'h42);
    send(8'h41);
    send(8'h42);
    idle();
    drain("ab");
    check("ab_consecutive", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);
    check_cursor("ab", 2, 0);

    // Right-edge wrap on row 0
    for (int i = 0; i < 77; i++) begin
      push(i + 2, 8'h61 + 8'(i % 26));
      send(8'h61 + 8'(i % 26));
    end
    idle();
    check_cursor("col79", 79, 0);
    push(79, 8'h5A);
    send(8'h5A);
    idle();
    check_cursor("wrap_row0", 0, 1);

    // Bottom-right corner wrap to home
    for (int i = 0; i < 58; i++) send(8'h0A);
    idle();
    check_cursor("lf_to_59", 0, 59);
    for (int i = 0; i < 79; i++) begin
      push(4720 + i, 8'h61 + 8'(i % 26));
      send(8'h61 + 8'(i % 26));
    end
    idle();
    check_cursor("corner", 79, 59);
    push(4799, 8'h5A);
    send(8'h5A);
    idle();
    check_cursor("wrap_home", 0, 0);
    drain("edges");

    // Control characters from (5,3)
    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      push(240 + i, 8'h30 + 8'(i));
      send(8'h30 + 8'(i));
    end
    idle();
    check_cursor("at_5_3", 5, 3);
    drain("pre_ctrl");
    base = wr_cnt;
    send(8'h0D); idle(); check_cursor("cr", 0, 3);
    send(8'h0A); idle(); check_cursor("lf", 0, 4);
    send(8'h08); idle(); check_cursor("bs1", 0, 4);
    send(8'h08); idle(); check_cursor("bs2", 0, 4);
    send(8'h07); idle(); check_cursor("bel", 0, 4);
    push(320, 8'h41);
    send(8'h41); idle(); check_cursor("after_a", 1, 4);
    drain("ctrl");
    check("ctrl_write_count", 32'(wr_cnt - base), 32'd1);

    // Form-feed from (10,10) with in_valid held during the sweep
    send(8'h0D);
    for (int i = 0; i < 6; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) begin
      push(800 + i, 8'h6B);
      send(8'h6B);
    end
    idle();
    check_cursor("at_10_10", 10, 10);
    drain("pre_ff");
    push_clear();
    push(0, 8'h51);
    send(8'h0C);
    @(negedge clk);
    in_data  = 8'h51;
    in_valid = 1'b1;
    check("ff_busy", 32'(busy), 32'd1);
    check_cursor("ff_hold", 10, 10);
    n = 0;
    while (!in_ready && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    check("ff_not_ready_cycles", 32'(n), 32'd4800);
    check_cursor("ff_home", 0, 0);
    @(posedge clk);
    idle();
    check_cursor("ff_after_q", 1, 0);
    drain("ff");

    // Asynchronous reset in the middle of a clear sweep
    push_clear();
    send(8'h0C);
    idle();
    n = 0;
    while (!(write_en && waddr == 13'd2000) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("mid_clear_reached_2000", 32'(waddr), 32'd2000);
    #2 resetn = 1'b0;
    #1 check_reset_values("mid_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_clear();
    base = wr_cnt;
    #2 resetn = 1'b1;
    drain("reclear");
    check("reclear_count", 32'(wr_cnt - base), 32'd4800);
    check("reclear_busy", 32'(busy), 32'd0);
    check_cursor("reclear", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
